// File: rtl/video_pkg.sv
// Shared view-mode encodings, luma weights and channel helpers for the video view path.
package video_pkg;

  localparam logic [3:0] MODE_RAW       = 4'd0;
  localparam logic [3:0] MODE_GRAY      = 4'd1;
  localparam logic [3:0] MODE_PROC_BASE = 4'd2;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  // Replicates the low w bits of ch MSB-first across a byte (4'hA -> 8'hAA).
  function automatic logic [7:0] expand_ch(input logic [7:0] ch, input int w);
    logic [7:0] r;
    logic [2:0] src;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      src           = 3'(w - 1 - (i % w));
      r[3'(7 - i)]  = ch[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/rgb_to_luma.sv
// Two-stage weighted RGB to 8-bit luma: registered products, then registered sum and shift.
module rgb_to_luma
  import video_pkg::*;
#(
  parameter int CH_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_i,
  input  logic [3*CH_W-1:0] rgb_i,
  output logic [7:0]        y_o,
  output logic              vld_o
);

  logic [7:0]  r8, g8, b8;
  logic [15:0] prod_r_q, prod_g_q, prod_b_q;
  logic        vld_p1_q, vld_p2_q;
  logic [7:0]  y_d, y_q;

  assign r8 = expand_ch(8'(rgb_i[3*CH_W-1 -: CH_W]), CH_W);
  assign g8 = expand_ch(8'(rgb_i[2*CH_W-1 -: CH_W]), CH_W);
  assign b8 = expand_ch(8'(rgb_i[CH_W-1 -: CH_W]), CH_W);

  // Weights sum to 256, so the 16-bit sum cannot overflow and Y never exceeds 255.
  assign y_d = 8'((prod_r_q + prod_g_q + prod_b_q) >> 8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      vld_p1_q <= 1'b0;
      y_q      <= '0;
      vld_p2_q <= 1'b0;
    end else begin
      prod_r_q <= {8'd0, COEF_R} * {8'd0, r8};
      prod_g_q <= {8'd0, COEF_G} * {8'd0, g8};
      prod_b_q <= {8'd0, COEF_B} * {8'd0, b8};
      vld_p1_q <= vld_i;
      y_q      <= y_d;
      vld_p2_q <= vld_p1_q;
    end
  end

  assign y_o   = y_q;
  assign vld_o = vld_p2_q;

endmodule

// File: rtl/video_view_select.sv
// Video view selector: luma conversion, delay alignment against processed streams,
// frame-boundary view switching, output coordinates and sticky misalignment flag.
module video_view_select
  import video_pkg::*;
#(
  parameter int CH_W       = 4,
  parameter int N_SRC      = 2,
  parameter int ALIGN_LAT  = 4,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_valid,
  input  logic [3*CH_W-1:0]    pix_rgb,
  input  logic [N_SRC-1:0]     proc_valid,
  input  logic [N_SRC*8-1:0]   proc_data,
  input  logic [3:0]           mode_req,
  output logic [7:0]           gray_out,
  output logic                 gray_valid,
  output logic [3*CH_W-1:0]    out_pixel,
  output logic                 out_valid,
  output logic [9:0]           out_x,
  output logic [8:0]           out_y,
  output logic                 frame_start,
  output logic [3:0]           mode_active,
  output logic                 sync_err
);

  localparam int PW = 3 * CH_W;

  logic [7:0]           y_raw;
  logic                 y_vld;
  logic [PW-1:0]        rgb_sr_q [ALIGN_LAT];
  logic [ALIGN_LAT-1:0] vld_sr_q;
  logic [PW-1:0]        rgb_al;
  logic [CH_W-1:0]      y_al;
  logic                 av;

  logic [PW-1:0]        out_pixel_d, out_pixel_q;
  logic                 out_valid_q;
  logic                 mis_d, sync_err_q;
  logic [3:0]           mode_active_q, mode_eff;
  logic [9:0]           x_q;
  logic [8:0]           y_q;
  logic                 last_beat, mode_ok;

  rgb_to_luma #(.CH_W(CH_W)) u_luma (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (pix_valid),
    .rgb_i (pix_rgb),
    .y_o   (y_raw),
    .vld_o (y_vld)
  );

  assign gray_out   = y_raw;
  assign gray_valid = y_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ALIGN_LAT; i++) rgb_sr_q[i] <= '0;
      vld_sr_q <= '0;
    end else begin
      rgb_sr_q[0] <= pix_rgb;
      for (int i = 1; i < ALIGN_LAT; i++) rgb_sr_q[i] <= rgb_sr_q[i-1];
      vld_sr_q <= {vld_sr_q[ALIGN_LAT-2:0], pix_valid};
    end
  end

  assign av     = vld_sr_q[ALIGN_LAT-1];
  assign rgb_al = rgb_sr_q[ALIGN_LAT-1];

  // Only the displayed top bits of luma need padding to the alignment point.
  generate
    if (ALIGN_LAT > 2) begin : g_pad
      logic [CH_W-1:0] pad_q [ALIGN_LAT-2];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < ALIGN_LAT-2; i++) pad_q[i] <= '0;
        end else begin
          pad_q[0] <= y_raw[7 -: CH_W];
          for (int i = 1; i < ALIGN_LAT-2; i++) pad_q[i] <= pad_q[i-1];
        end
      end
      assign y_al = pad_q[ALIGN_LAT-3];
    end else begin : g_nopad
      assign y_al = y_raw[7 -: CH_W];
    end
  endgenerate

  assign last_beat = out_valid_q && (x_q == 10'(IMG_WIDTH - 1)) && (y_q == 9'(IMG_HEIGHT - 1));
  assign mode_ok   = int'(mode_req) <= N_SRC + 1;
  // In a back-to-back stream the first pixel of the next frame is loaded on the boundary beat.
  assign mode_eff  = (last_beat && mode_ok) ? mode_req : mode_active_q;

  always_comb begin
    out_pixel_d = '0;
    mis_d       = 1'b0;
    if (av) begin
      if (mode_eff == MODE_RAW) begin
        out_pixel_d = rgb_al;
      end else if (mode_eff == MODE_GRAY) begin
        out_pixel_d = {3{y_al}};
      end else begin
        for (int k = 0; k < N_SRC; k++) begin
          if (mode_eff == 4'(int'(MODE_PROC_BASE) + k)) begin
            if (proc_valid[k]) out_pixel_d = {3{proc_data[8*k+7 -: CH_W]}};
            else               mis_d       = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_pixel_q   <= '0;
      sync_err_q    <= 1'b0;
      mode_active_q <= MODE_RAW;
      x_q           <= '0;
      y_q           <= '0;
    end else begin
      out_valid_q <= av;
      out_pixel_q <= out_pixel_d;
      sync_err_q  <= sync_err_q | mis_d;
      if (last_beat && mode_ok) mode_active_q <= mode_req;
      if (out_valid_q) begin
        if (x_q == 10'(IMG_WIDTH - 1)) begin
          x_q <= '0;
          y_q <= (y_q == 9'(IMG_HEIGHT - 1)) ? '0 : y_q + 9'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pixel   = out_pixel_q;
  assign out_x       = x_q;
  assign out_y       = y_q;
  assign frame_start = out_valid_q && (x_q == '0) && (y_q == '0);
  assign mode_active = mode_active_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_video_view_select.sv
// Directed bench for video_view_select on a reduced 8x4 frame so frame boundaries stay short.
`timescale 1ns/1ps
module tb_video_view_select;

  localparam int CH_W = 4, N_SRC = 2, ALIGN_LAT = 4, W = 8, H = 4, FP = W * H;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pix_valid = 1'b0;
  logic [11:0]      pix_rgb = '0;
  logic [1:0]       proc_valid = '0;
  logic [15:0]      proc_data = {8'h5A, 8'hC3};
  logic [3:0]       mode_req = '0;
  logic [7:0]       gray_out;
  logic             gray_valid;
  logic [11:0]      out_pixel;
  logic             out_valid;
  logic [9:0]       out_x;
  logic [8:0]       out_y;
  logic             frame_start;
  logic [3:0]       mode_active;
  logic             sync_err;

  video_view_select #(
    .CH_W(CH_W), .N_SRC(N_SRC), .ALIGN_LAT(ALIGN_LAT), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
    .proc_valid(proc_valid), .proc_data(proc_data), .mode_req(mode_req),
    .gray_out(gray_out), .gray_valid(gray_valid), .out_pixel(out_pixel),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .frame_start(frame_start),
    .mode_active(mode_active), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] pix;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        fs;
    logic [3:0]  mode;
    logic        err;
    logic [7:0]  gray;
  } beat_t;

  beat_t beats[$];
  always @(negedge clk)
    if (out_valid) beats.push_back({out_pixel, out_x, out_y, frame_start, mode_active, sync_err, gray_out});

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    pix_valid  = 1'b0;
    pix_rgb    = '0;
    proc_valid = '0;
    mode_req   = '0;
    repeat (3) step;
    rst_n = 1'b1;
  endtask

  // Streams n back-to-back pixels; proc_valid edits are given in driving-cycle numbers.
  task automatic stream(input int n, input logic [11:0] rgb, input int mreq_cyc, input logic [3:0] mreq,
                        input int drop_cyc, input int glitch_cyc);
    for (int c = 0; c < n + ALIGN_LAT + 4; c++) begin
      pix_valid = (c < n);
      pix_rgb   = (c < n) ? rgb : 12'h000;
      if (c == mreq_cyc) mode_req = mreq;
      proc_valid = 2'b11;
      if (c == drop_cyc)   proc_valid = 2'b01;
      if (c == glitch_cyc) proc_valid = 2'b10;
      step;
    end
    pix_valid = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [11:0] pix, input int x, input int y,
                          input logic fs, input logic [3:0] mode, input logic err);
    if (idx >= beats.size()) begin
      chk({tag, "_present"}, beats.size(), idx + 1);
    end else begin
      chk({tag, "_pix"},  beats[idx].pix,  pix);
      chk({tag, "_x"},    beats[idx].x,    x);
      chk({tag, "_y"},    beats[idx].y,    y);
      chk({tag, "_fs"},   beats[idx].fs,   fs);
      chk({tag, "_mode"}, beats[idx].mode, mode);
      chk({tag, "_err"},  beats[idx].err,  err);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int base;

    // Reset state
    rst_n = 1'b0;
    repeat (2) step;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_gray_valid", gray_valid, 0);
    chk("rst_gray_out", gray_out, 0);
    chk("rst_mode", mode_active, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_xy", {out_x, out_y}, 0);
    chk("rst_fs", frame_start, 0);

    // Latency: white then black, raw mode
    do_reset;
    pix_valid = 1'b1; pix_rgb = 12'hFFF; step;
    pix_rgb = 12'h000; step;
    pix_valid = 1'b0;
    chk("lat_gray_valid_c2", gray_valid, 1);
    chk("lat_gray_white", gray_out, 255);
    step;
    chk("lat_gray_valid_c3", gray_valid, 1);
    chk("lat_gray_black", gray_out, 0);
    step;
    chk("lat_out_valid_c4", out_valid, 0);
    step;
    chk("lat_out_valid_c5", out_valid, 1);
    chk("lat_out_white", out_pixel, 12'hFFF);
    chk("lat_fs_c5", frame_start, 1);
    chk("lat_x_c5", out_x, 0);
    step;
    chk("lat_out_black", out_pixel, 12'h000);
    chk("lat_x_c6", out_x, 1);
    chk("lat_fs_c6", frame_start, 0);
    step;
    chk("lat_out_valid_c7", out_valid, 0);
    chk("lat_out_zero_c7", out_pixel, 0);

    // Mid-frame request for source 0 takes effect only on the next frame
    do_reset;
    base = beats.size();
    stream(2 * FP, 12'h123, 10, 4'd2, -1, -1);
    chk("sw_count", beats.size() - base, 2 * FP);
    chk_beat("sw_first", base + 0, 12'h123, 0, 0, 1, 0, 0);
    chk_beat("sw_mid", base + 20, 12'h123, 4, 2, 0, 0, 0);
    chk_beat("sw_last", base + 31, 12'h123, 7, 3, 0, 0, 0);
    chk_beat("sw_next", base + 32, 12'hCCC, 0, 0, 1, 2, 0);

    // Luma view of pure red
    do_reset;
    base = beats.size();
    stream(2 * FP, 12'hF00, 0, 4'd1, -1, -1);
    chk_beat("luma_raw", base + 31, 12'hF00, 7, 3, 0, 0, 0);
    chk_beat("luma_first", base + 32, 12'h444, 0, 0, 1, 1, 0);
    chk_beat("luma_last", base + 63, 12'h444, 7, 3, 0, 1, 0);
    if (beats.size() > base + 32) chk("luma_gray", beats[base + 32].gray, 8'h4C);
    else chk("luma_gray_present", beats.size(), base + 33);

    // Source 1 view: dropped beat on the selected source, glitch on the other
    do_reset;
    base = beats.size();
    stream(2 * FP, 12'h0F0, 0, 4'd3, 40 + ALIGN_LAT, 35 + ALIGN_LAT);
    chk_beat("mis_raw", base + 31, 12'h0F0, 7, 3, 0, 0, 0);
    chk_beat("mis_first", base + 32, 12'h555, 0, 0, 1, 3, 0);
    chk_beat("mis_unsel", base + 35, 12'h555, 3, 0, 0, 3, 0);
    chk_beat("mis_drop", base + 40, 12'h000, 0, 1, 0, 3, 1);
    chk_beat("mis_after", base + 41, 12'h555, 1, 1, 0, 3, 1);
    chk("mis_sticky", sync_err, 1);

    // Out-of-range request at the boundary leaves the view unchanged
    base = beats.size();
    stream(2 * FP, 12'h0F0, 0, 4'd9, -1, -1);
    chk_beat("bad_first", base + 0, 12'h555, 0, 0, 1, 3, 1);
    chk_beat("bad_next", base + 32, 12'h555, 0, 0, 1, 3, 1);
    chk("bad_mode_hold", mode_active, 3);

    // Asynchronous reset in the middle of a frame
    do_reset;
    for (int c = 0; c < 26; c++) begin
      pix_valid = 1'b1; pix_rgb = 12'hABC; proc_valid = 2'b11;
      step;
    end
    chk("arst_pre_valid", out_valid, 1);
    chk("arst_pre_xy", {out_x, out_y}, {10'd5, 9'd2});
    chk("arst_pre_pix", out_pixel, 12'hABC);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_pix", out_pixel, 0);
    chk("arst_xy", {out_x, out_y}, 0);
    chk("arst_gray", {gray_valid, gray_out}, 0);
    pix_valid = 1'b0;
    step;
    rst_n = 1'b1;
    base = beats.size();
    pix_valid = 1'b1; pix_rgb = 12'h321; step;
    pix_valid = 1'b0;
    repeat (8) step;
    chk("arst_count", beats.size() - base, 1);
    chk_beat("arst_first", base, 12'h321, 0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
